// File: rtl/multicycle_ctrl.sv
// Main control FSM for the RV32I multi-cycle CPU.
// Sequences the shared datapath (PC, IR, register file, immediate generator, ALU, ALU-out
// register, unified memory port) through FETCH, DECODE, EXEC, MEM and WB, and traps on
// illegal opcodes.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   opcode/funct3/funct7_5  instruction fields from IR
//   br_taken            branch comparator result
//   mem_ready           memory completes the current request this cycle
//   mem_req/mem_we/addr_sel  memory request, store qualifier, address select (PC/alu_out)
//   ir_we/pc_we/pc_sel  IR load, PC update and PC source
//   reg_we/wb_sel       register write and writeback source
//   alu_a_sel/alu_b_sel/alu_op  ALU operand selects and operation
//   imm_type            immediate format
//   retire              one-cycle pulse on instruction completion
//   illegal             sticky trap flag
//   state               current state, for debug
module multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [3:0] alu_op,
  output logic [2:0] imm_type,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  localparam logic [2:0] ImmI     = 3'd0;
  localparam logic [2:0] ImmS     = 3'd1;
  localparam logic [2:0] ImmB     = 3'd2;
  localparam logic [2:0] ImmU     = 3'd3;
  localparam logic [2:0] ImmJ     = 3'd4;
  localparam logic [2:0] ImmShamt = 3'd5;

  state_e state_q, state_d;

  logic is_op, is_op_imm, is_load, is_store, is_branch, is_jalr, is_lui, is_auipc, is_jal;
  logic [3:0] alu_fn;

  assign is_op     = (opcode == OpcOp);
  assign is_op_imm = (opcode == OpcOpImm);
  assign is_load   = (opcode == OpcLoad);
  assign is_store  = (opcode == OpcStore);
  assign is_branch = (opcode == OpcBranch);
  assign is_jalr   = (opcode == OpcJalr);
  assign is_lui    = (opcode == OpcLui);
  assign is_auipc  = (opcode == OpcAuipc);
  assign is_jal    = (opcode == OpcJal);

  // funct3 -> ALU op; funct7_5 picks SUB only for register-register, SRA for both shifts.
  always_comb begin
    alu_fn = AluAdd;
    case (funct3)
      3'd0:    alu_fn = (is_op && funct7_5) ? AluSub : AluAdd;
      3'd1:    alu_fn = AluSll;
      3'd2:    alu_fn = AluSlt;
      3'd3:    alu_fn = AluSltu;
      3'd4:    alu_fn = AluXor;
      3'd5:    alu_fn = funct7_5 ? AluSra : AluSrl;
      3'd6:    alu_fn = AluOr;
      default: alu_fn = AluAnd;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    alu_op    = AluAdd;
    imm_type  = ImmI;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Speculative PC+imm into alu_out: branch/JAL target.
        alu_a_sel = 2'd1;
        alu_b_sel = 1'b1;
        if (is_store)                imm_type = ImmS;
        else if (is_branch)          imm_type = ImmB;
        else if (is_lui || is_auipc) imm_type = ImmU;
        else if (is_jal)             imm_type = ImmJ;
        if (is_jal) begin
          state_d = StWb;
        end else if (is_op || is_op_imm || is_load || is_store || is_branch || is_jalr ||
                     is_lui || is_auipc) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
        end
      end
      StExec: begin
        state_d = StWb;
        if (is_op) begin
          alu_op = alu_fn;
        end else if (is_op_imm) begin
          alu_b_sel = 1'b1;
          alu_op    = alu_fn;
          imm_type  = (funct3 == 3'd1 || funct3 == 3'd5) ? ImmShamt : ImmI;
        end else if (is_load || is_jalr) begin
          alu_b_sel = 1'b1;
          state_d   = is_load ? StMem : StWb;
        end else if (is_store) begin
          alu_b_sel = 1'b1;
          imm_type  = ImmS;
          state_d   = StMem;
        end else if (is_lui || is_auipc) begin
          alu_a_sel = is_lui ? 2'd2 : 2'd1;
          alu_b_sel = 1'b1;
          imm_type  = ImmU;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StTrap;
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
        if (is_load)              wb_sel = 2'd1;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        if (is_jal)               pc_sel = 2'd1;
        else if (is_jalr)         pc_sel = 2'd2;
      end
      StTrap: begin
        illegal = 1'b1;
      end
      default: begin
        // Unused encodings are treated as corruption and trapped.
        state_d = StTrap;
      end
    endcase

    // Reset kills every enable combinationally, aborting any in-flight instruction.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      reg_we    = 1'b0;
      wb_sel    = 2'd0;
      alu_a_sel = 2'd0;
      alu_b_sel = 1'b0;
      alu_op    = AluAdd;
      imm_type  = ImmI;
      retire    = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instructions cycle by cycle and checks every
// output against hand-computed values packed into one vector.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, alu_b_sel, retire, illegal;
  logic [1:0] pc_sel, wb_sel, alu_a_sel;
  logic [3:0] alu_op;
  logic [2:0] imm_type, state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.RESET_STATE(3'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .imm_type  (imm_type),
    .retire    (retire),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                alu_a_sel, alu_b_sel, alu_op, imm_type, retire, illegal};

  function automatic logic [24:0] ev(input logic [2:0] st, input logic mreq, input logic mwe,
                                     input logic asel, input logic irwe, input logic pcwe,
                                     input logic [1:0] pcsel, input logic regwe,
                                     input logic [1:0] wbsel, input logic [1:0] aa,
                                     input logic bb, input logic [3:0] op,
                                     input logic [2:0] imm, input logic ret, input logic ill);
    return {st, mreq, mwe, asel, irwe, pcwe, pcsel, regwe, wbsel, aa, bb, op, imm, ret, ill};
  endfunction

  task automatic chk(input string tag, input logic [24:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %07h expected %07h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called mid-cycle in FETCH; issues a zero-wait fetch and moves into DECODE.
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic bt);
    opcode = op; funct3 = f3; funct7_5 = f7; br_taken = bt; mem_ready = 1'b1;
    #1;
    chk("fetch", ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
  endtask

  // Single-register-result ALU instruction: FETCH, DECODE, EXEC, WB.
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [2:0] dimm, input logic [1:0] a,
                         input logic b, input logic [3:0] aop, input logic [2:0] imm);
    fetch(op, f3, f7, 1'b0);
    chk({tag, "_dec"}, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, dimm, 0, 0));
    step();
    chk({tag, "_exec"}, ev(2, 0, 0, 0, 0, 0, 0, 0, 0, a, b, aop, imm, 0, 0));
    step();
    chk({tag, "_wb"}, ev(4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    step();
  endtask

  initial begin
    rst = 1'b1; opcode = 7'h6f; funct3 = 3'd0; funct7_5 = 1'b0; br_taken = 1'b1;
    mem_ready = 1'b1;
    #3;
    chk("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("reset_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    run_alu("addi",   7'h13, 3'd0, 1'b0, 3'd0, 2'd0, 1'b1, 4'd0, 3'd0);
    run_alu("addi_f7", 7'h13, 3'd0, 1'b1, 3'd0, 2'd0, 1'b1, 4'd0, 3'd0);
    run_alu("srai",   7'h13, 3'd5, 1'b1, 3'd0, 2'd0, 1'b1, 4'd7, 3'd5);
    run_alu("slli",   7'h13, 3'd1, 1'b0, 3'd0, 2'd0, 1'b1, 4'd2, 3'd5);
    run_alu("sub",    7'h33, 3'd0, 1'b1, 3'd0, 2'd0, 1'b0, 4'd1, 3'd0);
    run_alu("srl",    7'h33, 3'd5, 1'b0, 3'd0, 2'd0, 1'b0, 4'd6, 3'd0);
    run_alu("and",    7'h33, 3'd7, 1'b0, 3'd0, 2'd0, 1'b0, 4'd9, 3'd0);
    run_alu("lui",    7'h37, 3'd0, 1'b0, 3'd3, 2'd2, 1'b1, 4'd0, 3'd3);
    run_alu("auipc",  7'h17, 3'd0, 1'b0, 3'd3, 2'd1, 1'b1, 4'd0, 3'd3);

    // Branch taken / not taken: 3 cycles, no register write.
    fetch(7'h63, 3'd0, 1'b0, 1'b1);
    chk("beq_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0));
    step();
    chk("beq_t_exec", ev(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    step();
    fetch(7'h63, 3'd0, 1'b0, 1'b0);
    step();
    chk("beq_nt_exec", ev(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step();

    // LW with three memory wait cycles: F D E M M M M W = 8 cycles.
    fetch(7'h03, 3'd2, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("lw_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    step();
    chk("lw_exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lw_mem_wait", ev(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    step();
    mem_ready = 1'b1;
    #1;
    chk("lw_mem_rdy", ev(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("lw_wb", ev(4, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    step();

    // JAL with one fetch wait cycle.
    opcode = 7'h6f; mem_ready = 1'b0;
    #1;
    chk("jal_fetch_wait", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("jal_fetch_hold", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    fetch(7'h6f, 3'd0, 1'b0, 1'b0);
    chk("jal_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 0, 0));
    step();
    chk("jal_wb", ev(4, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 1, 0));
    step();

    // JALR: EXEC rs1+imm, WB pc_sel=2, wb_sel=2.
    fetch(7'h67, 3'd0, 1'b0, 1'b0);
    step();
    chk("jalr_exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step();
    chk("jalr_wb", ev(4, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 0, 1, 0));
    step();

    // SW aborted by reset during MEM.
    fetch(7'h23, 3'd2, 1'b0, 1'b0);
    chk("sw_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
    step();
    chk("sw_exec", ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    mem_ready = 1'b0;
    step();
    chk("sw_mem_wait", ev(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    chk("sw_rst_abort", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("sw_rst_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk("post_rst_fetch", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("post_rst_hold", ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Full store with zero-wait memory: 4 cycles.
    fetch(7'h23, 3'd2, 1'b0, 1'b0);
    step();
    step();
    chk("sw_mem_rdy", ev(3, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step();
    chk("sw_done", ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Illegal opcode: sticky trap, no requests until reset.
    fetch(7'h7f, 3'd0, 1'b0, 1'b0);
    chk("ill_dec", ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    step();
    for (int i = 0; i < 20; i++) begin
      chk("trap", ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step();
    end
    rst = 1'b1;
    #1;
    chk("trap_rst", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("trap_exit_fetch", ev(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the team's RV32I multi-cycle CPU.
- Sequences the shared datapath through fetch, decode, execute, memory and writeback: PC, IR, register file, immediate generator, single ALU, ALU-out register and unified memory port.
- Selects the immediate format, ALU operation and operand muxes, and owns the memory request/ready handshake.
- Traps on illegal opcodes.

Parameters:
- RESET_STATE, 3'd0, state entered on reset (FETCH); fixed, exposed only for bench visibility.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0]; stable from the cycle after the IR write.
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- br_taken  in  1  branch comparator result on rs1/rs2 for the current funct3.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  store request (qualified by mem_req).
- addr_sel  out  1  0 = PC, 1 = alu_out as memory address.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_sel  out  2  0 = PC+4, 1 = alu_out, 2 = alu_out & ~1.
- reg_we  out  1  register file write.
- wb_sel  out  2  0 = alu_out, 1 = memory data, 2 = PC+4.
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- imm_type  out  3  0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT (zero-extended IR[24:20]).
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky trap flag.
- state  out  3  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. State is registered. All other outputs are combinational from state, opcode, funct3, funct7_5, br_taken and mem_ready. Unlisted outputs are 0.
- Reset: while rst is high, state=FETCH and every output is forced to 0, including mem_req and illegal. First request is issued the cycle after rst falls. Reset asserted mid-instruction aborts it with no write enables that cycle.
- FETCH:
  - mem_req=1, addr_sel=0.
  - If mem_ready: ir_we=1, go to DECODE. Otherwise stay, holding mem_req.
  - mem_ready in the same cycle as the request is legal (1-cycle fetch).
- DECODE:
  - alu_a_sel=1, alu_b_sel=1, alu_op=ADD; alu_out <= PC+imm. imm_type=B for branch, J for JAL, otherwise the opcode's native type.
  - JAL (1101111) goes to WB.
  - Legal opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 0110111, 0010111) go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC:
  - R-type: a=rs1, b=rs2. funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7_5=1 selects SUB (f3=0) or SRA (f3=5).
  - I-ALU: b=imm, imm_type=I. f3=1 or f3=5 use imm_type=SHAMT; f3=5 with funct7_5 selects SRA. funct7_5 is ignored for ADDI.
  - Load/store/JALR: ADD, b=imm, imm_type I/S/I.
  - LUI: a=zero, b=imm, U.
  - AUIPC: a=PC, b=imm, U.
  - Branch: no ALU write. pc_we=1, pc_sel = br_taken ? 1 : 0, retire=1, go to FETCH.
  - Load/store go to MEM. All others go to WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for stores.
  - Hold until mem_ready.
  - Load then goes to WB.
  - Store on ready: pc_we=1, pc_sel=0, retire=1, go to FETCH.
- WB:
  - reg_we=1, pc_we=1, retire=1, go to FETCH.
  - wb_sel: 1 for loads, 2 for JAL/JALR, else 0.
  - pc_sel: 1 for JAL, 2 for JALR, else 0.
- TRAP: illegal=1, all enables 0, no mem_req. Exits only on reset.
- Latency in cycles, assuming zero-wait memory:
  - 3: branch, JAL.
  - 4: ALU/LUI/AUIPC/JALR, store.
  - 5: load.
  - Each memory wait cycle adds 1.
- Simultaneous events: rst dominates everything. In FETCH and MEM, mem_ready with the state advance is the only completion condition. mem_ready outside FETCH/MEM is ignored.

Test Plan:
- ADDI (opcode 0x13, f3=0), mem_ready tied 1 -> state sequence 0,1,2,4,0. EXEC: alu_op=0, imm_type=0, alu_b_sel=1. WB: reg_we=1, pc_we=1, pc_sel=0, retire=1.
- SRAI (0x13, f3=5, f7_5=1) -> EXEC alu_op=7, imm_type=5. SUB (0x33, f3=0, f7_5=1) -> alu_op=1, alu_b_sel=0.
- BEQ (0x63), br_taken=1 -> sequence 0,1,2,0. EXEC: pc_we=1, pc_sel=1, reg_we=0. Repeat with br_taken=0 -> pc_sel=0.
- LW (0x03), mem_ready low for 3 MEM cycles -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles, then WB with wb_sel=1. Total 8 cycles.
- JAL (0x6F) -> sequence 0,1,4. DECODE imm_type=4. WB: wb_sel=2, pc_sel=1. Opcode 0x7F -> TRAP, illegal=1, mem_req stays 0 for 20 cycles until rst.
- rst pulse during MEM of SW -> all outputs 0 immediately. After release, state=0 with mem_req=1 and addr_sel=0. No mem_we seen.
